spike_train_decoder: RTL and testbench

Consumer-side counterpart to the QIF neuron: samples the neuron's `spike_out` line and turns the spike train into numeric readouts. It produces a per-window firing-rate count with a valid/ready handshake and, optionally, an inter-spike-interval (ISI) measurement. It sits between a neuron instance and downstream readout or learning logic.

---
 rtl/snn_pkg.sv | 25 ++
 rtl/spike_edge_detect.sv | 25 ++
 rtl/spike_train_decoder.sv | 176 +++++++++++++++++
 tb/tb_spike_train_decoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for spike-train consumers: decoder state encoding,
// default sizing constants and a saturating-increment helper.
package snn_pkg;

  // Decoder FSM states.
  typedef enum logic {
    DEC_IDLE  = 1'b0,
    DEC_COUNT = 1'b1
  } dec_state_e;

  // Default sizing for the spike-train decoder.
  localparam int DEF_WINDOW_CYCLES = 256;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_ISI_W         = 16;

  // Increment value by one, clamping at 2^width-1. Works on a 32-bit carrier
  // so callers of any width up to 32 can zero-extend in and truncate out.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : (value + 32'd1);
  endfunction

endpackage : snn_pkg

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for a spike level line. Keeps a registered copy of
// the previous sample; rise_o is combinational so a consumer can act on the
// event at the same edge that first samples the line high.
module spike_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // Previous-sample register; free-running so a level already high when a
  // consumer starts is not mistaken for a fresh event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule : spike_edge_detect

// File: rtl/spike_train_decoder.sv
// Spike-train decoder: counts spike events per fixed window and offers each
// window count through a one-entry valid/ready slot, flagging dropped
// results with a sticky overflow. Optional inter-spike-interval measurement
// is compiled in when the macro SPIKE_ISI_EN is defined; otherwise isi_out
// and isi_valid are tied low.
module spike_train_decoder
  import snn_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,  // >= 2
  parameter int CNT_W         = DEF_CNT_W,          // <= 32
  parameter int ISI_W         = DEF_ISI_W           // <= 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overflow,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid
);

  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  dec_state_e       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] acc_inc;
  logic             spike_evt;
  logic             active;

  spike_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (spike_in),
    .rise_o (spike_evt)
  );

  // Counting only happens in COUNT while enable is still asserted; a drop of
  // enable in COUNT is the exit cycle and contributes nothing.
  assign active = (state_q == DEC_COUNT) && enable;

  // State and rate-path registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEC_IDLE;
      win_q   <= '0;
      acc_q   <= '0;
      rate_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      rate_q  <= rate_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: FSM, window counter, accumulator and output slot.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    acc_d   = acc_q;
    rate_d  = rate_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    acc_inc = acc_q;

    // A transfer empties the slot unless a terminal reload below refills it.
    if (valid_q && rate_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      DEC_IDLE: begin
        if (enable) begin
          state_d = DEC_COUNT;
        end
      end
      DEC_COUNT: begin
        if (!enable) begin
          // Partial window is discarded; a pending sample stays in the slot.
          state_d = DEC_IDLE;
          win_d   = '0;
          acc_d   = '0;
        end else begin
          acc_inc = spike_evt ? CNT_W'(sat_inc(32'(acc_q), CNT_W)) : acc_q;
          if (win_q == WIN_LAST) begin
            // Terminal cycle: offer the count including this cycle's event.
            win_d = '0;
            acc_d = '0;
            if (!valid_q || rate_ready) begin
              rate_d  = acc_inc;
              valid_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            win_d = win_q + WIN_W'(1);
            acc_d = acc_inc;
          end
        end
      end
      default: begin
        state_d = DEC_IDLE;
      end
    endcase
  end

  assign rate_out   = rate_q;
  assign rate_valid = valid_q;
  assign overflow   = ovf_q;

`ifdef SPIKE_ISI_EN
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [ISI_W-1:0] isi_out_q, isi_out_d;
  logic             armed_q, armed_d;
  logic             isi_valid_q, isi_valid_d;

  // ISI registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_cnt_q   <= '0;
      isi_out_q   <= '0;
      armed_q     <= 1'b0;
      isi_valid_q <= 1'b0;
    end else begin
      isi_cnt_q   <= isi_cnt_d;
      isi_out_q   <= isi_out_d;
      armed_q     <= armed_d;
      isi_valid_q <= isi_valid_d;
    end
  end

  // Interval measurement: the first event only arms, later events report
  // count+1 (the edge-to-edge distance) and restart the counter. Leaving
  // COUNT or sitting in IDLE disarms and clears the counter.
  always_comb begin
    isi_cnt_d   = isi_cnt_q;
    isi_out_d   = isi_out_q;
    armed_d     = armed_q;
    isi_valid_d = 1'b0;
    if (active) begin
      if (spike_evt) begin
        isi_cnt_d = '0;
        armed_d   = 1'b1;
        if (armed_q) begin
          isi_out_d   = ISI_W'(sat_inc(32'(isi_cnt_q), ISI_W));
          isi_valid_d = 1'b1;
        end
      end else begin
        isi_cnt_d = ISI_W'(sat_inc(32'(isi_cnt_q), ISI_W));
      end
    end else begin
      isi_cnt_d = '0;
      armed_d   = 1'b0;
    end
  end

  assign isi_out   = isi_out_q;
  assign isi_valid = isi_valid_q;
`else
  assign isi_out   = '0;
  assign isi_valid = 1'b0;
`endif

endmodule : spike_train_decoder

// File: tb/tb_spike_train_decoder.sv
// Directed self-checking bench for spike_train_decoder (WINDOW_CYCLES=16).
module tb_spike_train_decoder;

  localparam int WIN   = 16;
  localparam int CNT_W = 8;
  localparam int ISI_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             spike_in;
  logic             rate_ready;
  logic [CNT_W-1:0] rate_out;
  logic             rate_valid;
  logic             overflow;
  logic [ISI_W-1:0] isi_out;
  logic             isi_valid;

  int n_checks = 0;
  int n_fail   = 0;

  spike_train_decoder #(
    .WINDOW_CYCLES (WIN),
    .CNT_W         (CNT_W),
    .ISI_W         (ISI_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .spike_in   (spike_in),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overflow   (overflow),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then leave the decoder idle with all inputs low.
  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; spike_in = 1'b0; rate_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Enable and take the IDLE->COUNT edge; the next tick is window cycle 0.
  task automatic start_count();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; spike_in = 1'b1; rate_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (rate_out !== 8'd0) begin
      n_fail++; $display("FAIL reset_rate_out: got %0d want 0", rate_out);
    end
    n_checks++;
    if (rate_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rate_valid: got %b want 0", rate_valid);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    n_checks++;
    if (isi_out !== 16'd0 || isi_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_isi: got out=%0d valid=%b want 0/0", isi_out, isi_valid);
    end
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_empty_window();
    apply_reset();
    start_count();
    for (int i = 0; i < WIN; i++) begin
      tick();
      if (i == WIN - 2) begin
        n_checks++;
        if (rate_valid !== 1'b0) begin
          n_fail++; $display("FAIL empty_early_valid: got %b want 0 at cycle %0d", rate_valid, i);
        end
      end
    end
    n_checks++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd0) begin
      n_fail++; $display("FAIL empty_window: got valid=%b rate=%0d want 1/0", rate_valid, rate_out);
    end
    $display("test_empty_window: rate_out=%0d rate_valid=%b", rate_out, rate_valid);
  endtask

  task automatic test_rate_count();
    logic [15:0] pat;
    pat = 16'h7AAA;  // pulses at 1,3,5,7,9 and a level held over 11..14
    apply_reset();
    rate_ready = 1'b1;
    start_count();
    for (int i = 0; i < WIN; i++) begin
      spike_in = pat[i];
      tick();
    end
    spike_in = 1'b0;
    n_checks++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd6) begin
      n_fail++; $display("FAIL rate_six: got valid=%b rate=%0d want 1/6", rate_valid, rate_out);
    end
    tick();
    n_checks++;
    if (rate_valid !== 1'b0) begin
      n_fail++; $display("FAIL rate_pulse_width: got valid=%b want 0", rate_valid);
    end
`ifndef SPIKE_ISI_EN
    n_checks++;
    if (isi_out !== 16'd0 || isi_valid !== 1'b0) begin
      n_fail++; $display("FAIL isi_tied_off: got out=%0d valid=%b want 0/0", isi_out, isi_valid);
    end
`endif
    $display("test_rate_count: rate_out=6 window done, valid now %b", rate_valid);
  endtask

  task automatic test_backpressure();
    logic [15:0] pat;
    pat = 16'h0222;  // 3 events per window
    apply_reset();
    start_count();
    for (int i = 0; i < 40; i++) begin
      spike_in = pat[i % 16];
      tick();
      if (i == 15) begin
        n_checks++;
        if (rate_valid !== 1'b1 || rate_out !== 8'd3 || overflow !== 1'b0) begin
          n_fail++; $display("FAIL bp_first: got valid=%b rate=%0d ovf=%b want 1/3/0", rate_valid, rate_out, overflow);
        end
      end
      if (i == 31) begin
        n_checks++;
        if (overflow !== 1'b1 || rate_out !== 8'd3) begin
          n_fail++; $display("FAIL bp_drop: got ovf=%b rate=%0d want 1/3", overflow, rate_out);
        end
      end
    end
    n_checks++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd3) begin
      n_fail++; $display("FAIL bp_hold: got valid=%b rate=%0d want 1/3", rate_valid, rate_out);
    end
    spike_in = 1'b0;
    rate_ready = 1'b1;
    tick();
    n_checks++;
    if (rate_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL bp_transfer: got valid=%b ovf=%b want 0/1", rate_valid, overflow);
    end
    $display("test_backpressure: held 3, overflow=%b after transfer", overflow);
  endtask

  task automatic test_terminal_spike();
    logic [15:0] pat;
    pat = 16'h8008;  // event at cycle 3 and on the terminal cycle 15
    apply_reset();
    rate_ready = 1'b1;
    start_count();
    for (int i = 0; i < WIN; i++) begin
      spike_in = pat[i];
      tick();
    end
    n_checks++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd2) begin
      n_fail++; $display("FAIL terminal_spike: got valid=%b rate=%0d want 1/2", rate_valid, rate_out);
    end
    spike_in = 1'b0;
    for (int i = 0; i < WIN; i++) tick();
    n_checks++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd0) begin
      n_fail++; $display("FAIL terminal_next_window: got valid=%b rate=%0d want 1/0", rate_valid, rate_out);
    end
    $display("test_terminal_spike: closing window 2, next window 0");
  endtask

  task automatic test_enable_drop();
    logic [15:0] pat;
    pat = 16'h0004;
    apply_reset();
    rate_ready = 1'b1;
    start_count();
    for (int i = 0; i < 6; i++) begin
      spike_in = (i == 1 || i == 3);
      tick();
    end
    spike_in = 1'b0;
    enable = 1'b0;
    tick();
    start_count();
    for (int i = 0; i < WIN; i++) begin
      spike_in = pat[i];
      tick();
    end
    spike_in = 1'b0;
    n_checks++;
    if (rate_valid !== 1'b1 || rate_out !== 8'd1) begin
      n_fail++; $display("FAIL enable_drop: got valid=%b rate=%0d want 1/1", rate_valid, rate_out);
    end
    $display("test_enable_drop: partial count discarded, rate_out=%0d", rate_out);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_count();
    for (int i = 0; i < 35; i++) begin
      spike_in = (i == 1 || i == 18 || i == 33);
      tick();
    end
    spike_in = 1'b0;
    n_checks++;
    if (rate_valid !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got valid=%b ovf=%b want 1/1", rate_valid, overflow);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rate_valid !== 1'b0 || overflow !== 1'b0 || rate_out !== 8'd0) begin
      n_fail++; $display("FAIL mid_async_clear: got valid=%b ovf=%b rate=%0d want 0/0/0", rate_valid, overflow, rate_out);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      tick();
      if (rate_valid !== 1'b0) begin
        n_checks++;
        n_fail++; $display("FAIL mid_early_sample: got valid=1 want 0 at tick %0d", i);
      end
    end
    n_checks++;
    tick();
    if (rate_valid !== 1'b1 || rate_out !== 8'd0) begin
      n_fail++; $display("FAIL mid_full_window: got valid=%b rate=%0d want 1/0", rate_valid, rate_out);
    end
    $display("test_reset_mid: cleared, fresh window rate_out=%0d", rate_out);
  endtask

`ifdef SPIKE_ISI_EN
  task automatic test_isi();
    apply_reset();
    rate_ready = 1'b1;
    start_count();
    for (int n = 0; n <= 17 + 70000; n++) begin
      spike_in = (n == 10 || n == 17 || n == 17 + 70000);
      tick();
      if (n == 10) begin
        n_checks++;
        if (isi_valid !== 1'b0) begin
          n_fail++; $display("FAIL isi_arm: got valid=%b want 0", isi_valid);
        end
      end
      if (n == 17) begin
        n_checks++;
        if (isi_valid !== 1'b1 || isi_out !== 16'd7) begin
          n_fail++; $display("FAIL isi_seven: got valid=%b out=%0d want 1/7", isi_valid, isi_out);
        end
      end
      if (n == 18) begin
        n_checks++;
        if (isi_valid !== 1'b0) begin
          n_fail++; $display("FAIL isi_strobe_width: got valid=%b want 0", isi_valid);
        end
      end
    end
    spike_in = 1'b0;
    n_checks++;
    if (isi_valid !== 1'b1 || isi_out !== 16'd65535) begin
      n_fail++; $display("FAIL isi_saturate: got valid=%b out=%0d want 1/65535", isi_valid, isi_out);
    end
    $display("test_isi: isi_out=%0d", isi_out);
  endtask
`endif

  initial begin
    test_reset();
    test_empty_window();
    test_rate_count();
    test_backpressure();
    test_terminal_spike();
    test_enable_drop();
    test_reset_mid();
`ifdef SPIKE_ISI_EN
    test_isi();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spike_train_decoder
